// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared defaults, tag record and state encoding for the Sobel frame sequencer
// Contents: image size defaults, core latency beyond one row, FSM states, centre-tag record,
//           counter width helper.
package sobel_pkg;
  localparam int IMG_WIDTH_DEF  = 695;
  localparam int IMG_HEIGHT_DEF = 480;
  localparam int DATA_W_DEF     = 32;
  // Strobes the core needs beyond one full row before the first centred result appears.
  localparam int CORE_LAT       = 4;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
    logic border;
  } tags_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sobel_stream_ctrl_if.sv
// rtl/sobel_stream_ctrl_if.sv - pixel-in / result-out handshake bundle of the Sobel frame sequencer
// Signals: in_valid/in_ready/in_data (source side), out_valid/out_ready/out_data and the
//          sof/eol/eof/border result tags (consumer side).
// Modports: slave = controller view, master = source/consumer view.
interface sobel_stream_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sof;
  logic              out_eol;
  logic              out_eof;
  logic              out_border;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol, out_eof, out_border
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol, out_eof, out_border
  );
endinterface

// File: rtl/sobel_pos_counter.sv
// rtl/sobel_pos_counter.sv - row/column position counter with frame tag decode
// Ports: clock, reset_n (async active-low), clr (restart at 0,0), adv (step one pixel),
//        tags (sof/eol/eof/border of the current position).
module sobel_pos_counter
  import sobel_pkg::*;
#(
  parameter int W = 8,
  parameter int H = 4
) (
  input  logic  clock,
  input  logic  reset_n,
  input  logic  clr,
  input  logic  adv,
  output tags_t tags
);
  localparam int CW = cnt_w(W);
  localparam int RW = cnt_w(H);
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (col == COL_LAST) begin
        col <= '0;
        // Wrapping at the end of the frame leaves the counter ready for the next one.
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_comb begin
    tags        = '0;
    tags.sof    = (row == '0) && (col == '0);
    tags.eol    = (col == COL_LAST);
    tags.eof    = (row == ROW_LAST) && (col == COL_LAST);
    tags.border = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
  end
endmodule

// File: rtl/sobel_stream_ctrl.sv
// rtl/sobel_stream_ctrl.sv - frame sequencer gating a streaming Sobel core and tagging its results
// Ports: clock, reset_n (async active-low), start/busy/done (frame control),
//        core_en/core_in/core_out (Sobel core stream), bus (pixel in, tagged result out).
module sobel_stream_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              core_en,
  output logic [DATA_W-1:0] core_in,
  input  logic [DATA_W-1:0] core_out,
  sobel_stream_ctrl_if.slave bus
);
  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT + IMG_WIDTH + CORE_LAT - 1;
  localparam int SCW   = $clog2(TOTAL) + 1;
  // scnt holds the number of strobes already issued, so strobe e sees scnt == e-1.
  localparam logic [SCW-1:0] FIRST_OUT   = SCW'(IMG_WIDTH + CORE_LAT - 1);
  localparam logic [SCW-1:0] LAST_STROBE = SCW'(TOTAL - 1);

  state_t         state, state_nx;
  logic [SCW-1:0] scnt;
  logic           slot_free;
  logic           start_acc;
  logic           in_accept;
  logic           out_retire;
  tags_t          in_tags;
  tags_t          c_tags;
  logic           unused_in_tags;

  assign slot_free  = !bus.out_valid || bus.out_ready;
  assign start_acc  = (state == IDLE) && start;
  assign in_accept  = bus.in_valid && bus.in_ready;
  assign out_retire = bus.out_valid && bus.out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    busy         = (state != IDLE);
    done         = 1'b0;
    bus.in_ready = 1'b0;
    core_en      = 1'b0;
    core_in      = '0;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        bus.in_ready = slot_free;
        core_en      = bus.in_valid && slot_free;
        core_in      = bus.in_data;
        if (core_en && in_tags.eof) state_nx = FLUSH;
      end
      FLUSH: begin
        // Zeros push the last rows through the line buffer.
        core_en = slot_free;
        if (core_en && (scnt == LAST_STROBE)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (out_retire) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A strobe only happens when the output slot is free, so the core holds and out_data
  // stays stable while the consumer stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scnt          <= '0;
      bus.out_valid <= 1'b0;
    end else if (start_acc) begin
      scnt          <= '0;
      bus.out_valid <= 1'b0;
    end else if (core_en) begin
      scnt <= scnt + 1'b1;
      if (scnt >= FIRST_OUT) bus.out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  sobel_pos_counter #(.W(IMG_WIDTH), .H(IMG_HEIGHT)) u_in_pos (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (start_acc),
    .adv     (in_accept),
    .tags    (in_tags)
  );

  // Centre position tracks the result currently presented; it steps when that result retires.
  sobel_pos_counter #(.W(IMG_WIDTH), .H(IMG_HEIGHT)) u_c_pos (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (start_acc),
    .adv     (out_retire),
    .tags    (c_tags)
  );

  // Only the end-of-frame decode of the input side steers the sequencer.
  assign unused_in_tags = in_tags.sof ^ in_tags.eol ^ in_tags.border;

  assign bus.out_data   = core_out;
  assign bus.out_sof    = bus.out_valid && c_tags.sof;
  assign bus.out_eol    = bus.out_valid && c_tags.eol;
  assign bus.out_eof    = bus.out_valid && c_tags.eof;
  assign bus.out_border = bus.out_valid && c_tags.border;
endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// tb/tb_sobel_stream_ctrl.sv - scoreboard bench for sobel_stream_ctrl with a behavioural Sobel core
module tb_sobel_stream_ctrl;
  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;
  localparam int T = N + W + 3;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tags;
  } exp_t;

  typedef struct {
    int vmode;
    int rmode;
    int imode;
    int xstart;
    int exp_strobes;
    int exp_first;
    int exp_results;
    int exp_border;
    int exp_eol;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        core_en;
  logic [31:0] core_in;
  logic [31:0] core_out;
  logic        model_clr;

  sobel_stream_ctrl_if #(.DATA_W(32)) bus ();

  sobel_stream_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(32)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .core_en  (core_en),
    .core_in  (core_in),
    .core_out (core_out),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  int   n_vec = 0;
  int   n_bad = 0;
  int   img[N];
  exp_t sb[$];

  logic [31:0] sr[0:2*W+2];
  logic [31:0] pipe1;

  function automatic int sob(input int a[9]);
    int gx, gy;
    gx = (a[2] + 2*a[5] + a[8]) - (a[0] + 2*a[3] + a[6]);
    gy = (a[6] + 2*a[7] + a[8]) - (a[0] + 2*a[1] + a[2]);
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  function automatic int core_win();
    int a[9];
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        a[(dr+1)*3 + dc + 1] = int'(sr[W + 1 - (dr*W + dc)]);
    return sob(a);
  endfunction

  function automatic int ref_val(input int p);
    int a[9];
    int q;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        q = p + dr*W + dc;
        a[(dr+1)*3 + dc + 1] = (q >= 0 && q < N) ? img[q] : 0;
      end
    return sob(a);
  endfunction

  // Behavioural core: 2-row line buffer plus two pipeline stages, frozen while en is low.
  always @(posedge clock) begin
    if (model_clr) begin
      for (int i = 0; i <= 2*W+2; i++) sr[i] <= '0;
      pipe1    <= '0;
      core_out <= '0;
    end else if (core_en) begin
      for (int i = 2*W+2; i > 0; i--) sr[i] <= sr[i-1];
      sr[0]    <= core_in;
      pipe1    <= 32'(core_win());
      core_out <= pipe1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input int p);
    exp_t e;
    int r, c;
    r = p / W;
    c = p % W;
    e.data = 32'(ref_val(p));
    e.tags = {p == 0, c == W-1, p == N-1, (r == 0 || r == H-1 || c == 0 || c == W-1)};
    return e;
  endfunction

  task automatic run_frame(input vec_t v, input int abort_at);
    int strobes, first_v, results, borders, sofs, eols, eofs, dones, acc;
    int stall_bad, stall_cyc, post, post_bad, drain_cyc, cyc;
    logic iv, r, stall, prev_stall;
    logic [31:0] prev_data;
    exp_t e;
    strobes = 0; first_v = -1; results = 0; borders = 0; sofs = 0; eols = 0; eofs = 0;
    dones = 0; acc = 0; stall_bad = 0; stall_cyc = 0; post = -1; post_bad = 0; drain_cyc = 0;
    prev_stall = 1'b0; prev_data = '0;
    for (int i = 0; i < N; i++) img[i] = (v.imode != 0) ? int'($urandom_range(0, 255)) : i;
    sb.delete();
    @(negedge clock);
    model_clr = 1'b1; start = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clock);
    model_clr = 1'b0; start = 1'b0;
    for (cyc = 0; cyc < 1500 && post != 0; cyc++) begin
      @(negedge clock);
      case (v.vmode)
        0:       iv = 1'b1;
        1:       iv = (cyc % 2 == 0);
        default: iv = 1'($urandom_range(0, 1));
      endcase
      case (v.rmode)
        0:       r = 1'b1;
        1:       r = !(cyc >= 25 && cyc < 30);
        default: r = 1'($urandom_range(0, 1));
      endcase
      start = (v.xstart != 0) && dones == 0 && post < 0 && (cyc == 15 || strobes >= T);
      if (v.xstart != 0 && strobes >= T && post < 0) begin
        r = (drain_cyc >= 2);
        drain_cyc++;
      end
      bus.in_valid  = iv;
      bus.out_ready = r;
      bus.in_data   = (acc < N) ? img[acc] : 0;
      #1;
      if (post > 0) begin
        if (busy || core_en || bus.in_ready || bus.out_valid) post_bad++;
        post--;
      end else begin
        if (bus.out_valid && first_v < 0) first_v = strobes;
        stall = bus.out_valid && !bus.out_ready;
        if (stall) begin
          stall_cyc++;
          if (core_en || bus.in_ready) stall_bad++;
          if (prev_stall && bus.out_data !== prev_data) stall_bad++;
        end
        prev_stall = stall;
        prev_data  = bus.out_data;
        if (core_en) strobes++;
        if (bus.in_valid && bus.in_ready) begin
          sb.push_back(mk_exp(acc));
          acc++;
          if (acc == abort_at) return;
        end
        if (bus.out_valid && bus.out_ready) begin
          results++;
          borders += int'(bus.out_border);
          sofs    += int'(bus.out_sof);
          eols    += int'(bus.out_eol);
          eofs    += int'(bus.out_eof);
          if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("result_data", bus.out_data, e.data);
            chk("result_tags", {bus.out_sof, bus.out_eol, bus.out_eof, bus.out_border}, e.tags);
          end
        end
        if (done) begin
          dones++;
          post = 4;
        end
      end
    end
    start = 1'b0;
    chk("frame_finished", post, 0);
    chk("strobes", strobes, v.exp_strobes);
    chk("first_valid_strobe", first_v, v.exp_first);
    chk("results", results, v.exp_results);
    chk("done_pulses", dones, 1);
    chk("idle_after_done", post_bad, 0);
    chk("border_count", borders, v.exp_border);
    chk("eol_count", eols, v.exp_eol);
    chk("sof_count", sofs, 1);
    chk("eof_count", eofs, 1);
    chk("sb_left", sb.size(), 0);
    chk("stall_hold", stall_bad, 0);
    if (v.rmode == 1) chk("stall_seen", stall_cyc >= 5, 1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{vmode: 0, rmode: 0, imode: 0, xstart: 0, exp_strobes: T, exp_first: W+4,
                exp_results: N, exp_border: 20, exp_eol: H};
    vecs[1] = '{vmode: 0, rmode: 1, imode: 0, xstart: 0, exp_strobes: T, exp_first: W+4,
                exp_results: N, exp_border: 20, exp_eol: H};
    vecs[2] = '{vmode: 1, rmode: 0, imode: 0, xstart: 0, exp_strobes: T, exp_first: W+4,
                exp_results: N, exp_border: 20, exp_eol: H};
    vecs[3] = '{vmode: 2, rmode: 2, imode: 1, xstart: 0, exp_strobes: T, exp_first: W+4,
                exp_results: N, exp_border: 20, exp_eol: H};
    vecs[4] = '{vmode: 0, rmode: 0, imode: 1, xstart: 1, exp_strobes: T, exp_first: W+4,
                exp_results: N, exp_border: 20, exp_eol: H};

    reset_n = 1'b0; start = 1'b0; model_clr = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", {busy, done, bus.in_ready, core_en, bus.out_valid,
                          bus.out_sof, bus.out_eol, bus.out_eof, bus.out_border}, 0);
    reset_n = 1'b1; model_clr = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(vecs[i], -1);

    // Mid-frame reset at pixel 17, then a clean frame.
    run_frame(vecs[0], 17);
    reset_n = 1'b0;
    #1;
    chk("reset_mid_outputs", {busy, done, bus.in_ready, core_en, bus.out_valid,
                              bus.out_sof, bus.out_eol, bus.out_eof, bus.out_border}, 0);
    repeat (3) @(negedge clock);
    chk("reset_hold_outputs", {busy, done, bus.in_ready, core_en, bus.out_valid,
                               bus.out_sof, bus.out_eol, bus.out_eof, bus.out_border}, 0);
    reset_n = 1'b1;
    run_frame(vecs[0], -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
